hilo_div_responder: RTL and testbench

- Sequential radix-2 restoring divider on the responder side of the EX-stage valid/done handshake.
- The ALU holds `valid` and stalls on `~done`. This block latches the operands, iterates one quotient bit per cycle, and returns `c = {remainder, quotient}` for DIV/DIVU into HI/LO.
- Signed mode truncates toward zero (MIPS semantics).

---
 rtl/hilo_div_responder.sv | 180 ++++++++++++++++++
 tb/tb_hilo_div_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hilo_div_responder.sv
// -----------------------------------------------------------------------------
// hilo_div_responder
//
// Sequential radix-2 restoring divider on the responder side of the EX-stage
// valid/done handshake. The ALU holds valid high and stalls until done. The
// operands are latched at start. One quotient bit is produced per cycle. The
// result {remainder, quotient} is returned for DIV (signed, truncating toward
// zero) and DIVU (unsigned) into HI/LO.
//
// Ports:
//   clk     - core clock; all state updates on the rising edge
//   resetn  - synchronous reset, active low
//   valid   - request; held high by the initiator until done is seen
//   sig     - 1 = signed (DIV), 0 = unsigned (DIVU); sampled with operands
//   _a      - dividend, sampled at start
//   _b      - divisor, sampled at start
//   done    - one-cycle result-valid pulse
//   _c      - {remainder, quotient}; stable from done until the next start
//
// Build option:
//   DIV_EARLY_ZERO_EN - when defined, a start with a zero divisor skips the
//                       iterations and produces done two cycles after start.
// -----------------------------------------------------------------------------
module hilo_div_responder #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic               sig,
  input  logic [WIDTH-1:0]   _a,
  input  logic [WIDTH-1:0]   _b,
  output logic               done,
  output logic [2*WIDTH-1:0] _c
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic               sig_q;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] c_q;

  logic [WIDTH-1:0]        abs_a;
  logic [WIDTH-1:0]        abs_b;
  logic                    start_zero;
  logic signed [WIDTH:0]   rem_sh;
  logic signed [WIDTH:0]   trial;
  logic                    trial_neg;
  logic [WIDTH-1:0]        rem_fix;
  logic [WIDTH-1:0]        quo_fix;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic s);
    return (s && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  assign abs_a = magnitude(_a, sig);
  assign abs_b = magnitude(_b, sig);

`ifdef DIV_EARLY_ZERO_EN
  assign start_zero = (_b == '0);
`else
  assign start_zero = 1'b0;
`endif

  // Iteration: shift {rem, quo} left by one and trial-subtract the divisor.
  // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits.
  // Its MSB is therefore a reliable sign of the trial.
  assign rem_sh    = $signed({rem, quo[WIDTH-1]});
  assign trial     = rem_sh - $signed({1'b0, dvsr});
  assign trial_neg = trial[WIDTH];

  // Sign fix. With a zero divisor the iterations leave quotient = all-ones
  // and remainder = |a|. Re-applying the dividend sign to the remainder
  // restores the original a. The quotient negation is suppressed.
  assign rem_fix = (sig_q && sign_a) ? negate(rem) : rem;
  assign quo_fix = b_zero ? '1 :
                   ((sig_q && (sign_a ^ sign_b)) ? negate(quo) : quo);

  assign done = (state == S_DONE);
  assign _c   = c_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (valid) begin
          // A zero divisor with the early option goes straight to the fix
          // step, which then writes {a, all-ones}.
          state_nxt = start_zero ? S_FIX : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!valid)               state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_FIX;
      end
      S_FIX: begin
        state_nxt = valid ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sig_q  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      c_q    <= '0;
    end else begin
      unique case (state)
        // Start: capture signs and load operand magnitudes.
        S_IDLE: begin
          if (valid) begin
            sig_q  <= sig;
            sign_a <= _a[WIDTH-1];
            sign_b <= _b[WIDTH-1];
            b_zero <= (_b == '0);
            dvsr   <= abs_b;
            cnt    <= '0;
            if (start_zero) begin
              rem <= abs_a;
              quo <= '1;
            end else begin
              rem <= '0;
              quo <= abs_a;
            end
          end
        end
        // Iterate: one quotient bit per cycle.
        S_BUSY: begin
          if (valid) begin
            rem <= trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial_neg};
            cnt <= cnt + 1'b1;
          end
        end
        // Fix: apply signs and publish the result.
        S_FIX: begin
          if (valid) c_q <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_responder.sv
module tb_hilo_div_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        sig;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [63:0] c;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DIV_EARLY_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  always #5 clk = ~clk;

  hilo_div_responder #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .sig    (sig),
    ._a     (a),
    ._b     (b),
    .done   (done),
    ._c     (c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request in the current cycle t and wait for done.
  task automatic run(input logic s, input logic [31:0] av, input logic [31:0] bv,
                     input int lat, input logic [63:0] ec, input string tag);
    int first;
    first = -1;
    valid = 1'b1; sig = s; a = av; b = bv;
    for (int k = 1; k <= 100 && first < 0; k++) begin
      step();
      if (done === 1'b1) first = k;
    end
    valid = 1'b0;
    chk({tag, " latency"}, 64'(first), 64'(lat));
    chk({tag, " result"}, c, ec);
    step();
    chk({tag, " done width"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int first;
    int second;
    logic [63:0] c_prev;

    resetn = 1'b0; valid = 1'b0; sig = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset c", c, 64'd0);
    resetn = 1'b1;
    step();

    run(1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14}, "divu 100/7");
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div -7/2");
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 34, {32'h0000_0001, 32'hFFFF_FFFD}, "div 7/-2");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h0, 32'h8000_0000}, "div overflow");
    run(1'b0, 32'd5, 32'd0, ZLAT, {32'd5, 32'hFFFF_FFFF}, "divu 5/0");
    run(1'b1, 32'hFFFF_FFFB, 32'd0, ZLAT, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div -5/0");

    // Abort at t+10, restart at t+12 with 9/4.
    c_prev = c;
    first = -1;
    valid = 1'b1; sig = 1'b0; a = 32'd1000; b = 32'd3;
    for (int k = 1; k <= 100 && first < 0; k++) begin
      step();
      if (done === 1'b1) first = k;
      if (k == 10) valid = 1'b0;
      if (k == 11) chk("abort c held", c, c_prev);
      if (k == 12) begin valid = 1'b1; a = 32'd9; b = 32'd4; end
    end
    valid = 1'b0;
    chk("abort restart latency", 64'(first), 64'd46);
    chk("abort restart result", c, {32'd1, 32'd2});
    step();

    // Back-to-back with valid held; operands switch during the done cycle.
    first = -1; second = -1;
    valid = 1'b1; sig = 1'b0; a = 32'd100; b = 32'd7;
    for (int k = 1; k <= 120 && second < 0; k++) begin
      step();
      if (k == 35) chk("b2b done low after pulse", {63'd0, done}, 64'd0);
      if (done === 1'b1) begin
        if (first < 0) begin
          first = k;
          chk("b2b first result", c, {32'd2, 32'd14});
          a = 32'd50; b = 32'd5;
        end else begin
          second = k;
        end
      end
    end
    valid = 1'b0;
    chk("b2b first latency", 64'(first), 64'd34);
    chk("b2b second latency", 64'(second), 64'd69);
    chk("b2b second result", c, {32'd0, 32'd10});
    step();

    // Reset in the middle of a divide.
    first = -1;
    valid = 1'b1; sig = 1'b0; a = 32'd100; b = 32'd7;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done === 1'b1 && first < 0) first = k;
    end
    resetn = 1'b0; valid = 1'b0;
    step();
    chk("midreset no done before", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midreset done", {63'd0, done}, 64'd0);
    chk("midreset c", c, 64'd0);
    resetn = 1'b1;
    step();
    run(1'b0, 32'd9, 32'd4, 34, {32'd1, 32'd2}, "after reset 9/4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
